axi_rd_arbiter: RTL and testbench

Parametrised N-channel AXI3 read-path arbiter sitting between the core's internal read requesters (instruction cache, data cache, uncached port, …) and the single AXI read master of the CPU top. It grants requests round-robin onto one registered AR channel, tags each burst with the channel index as ARID, and routes R beats back by RID. It allows one outstanding burst per channel and checks every returned burst's length against the requested ARLEN.

---
 rtl/axi_rd_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// N-channel AXI3 read arbiter: round-robin AR grant with channel index as ARID,
// RID-based R routing, one outstanding burst per channel with burst-length checking.
`timescale 1ns/1ps

module axi_rd_arbiter #(
   parameter int unsigned N_CH   = 3,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4
) (
   input  logic                     aclk,
   input  logic                     areset,

   input  logic [N_CH-1:0]          req_valid,
   output logic [N_CH-1:0]          req_ready,
   input  logic [N_CH*ADDR_W-1:0]   req_addr,
   input  logic [N_CH*8-1:0]        req_len,
   input  logic [N_CH*3-1:0]        req_size,

   output logic [N_CH-1:0]          resp_valid,
   input  logic [N_CH-1:0]          resp_ready,
   output logic [DATA_W-1:0]        resp_data,
   output logic                     resp_last,
   output logic                     resp_err,
   output logic                     proto_err,

   output logic [ID_W-1:0]          arid,
   output logic [ADDR_W-1:0]        araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic [1:0]               arlock,
   output logic [3:0]               arcache,
   output logic [2:0]               arprot,
   output logic                     arvalid,
   input  logic                     arready,

   input  logic [ID_W-1:0]          rid,
   input  logic [DATA_W-1:0]        rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready
);

   localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned SIZE_W = 3;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [SIZE_W-1:0] size;
   } ar_payload_t;

   logic [N_CH-1:0]  busy;
   logic [LEN_W-1:0] cnt     [N_CH];
   logic [LEN_W-1:0] exp_len [N_CH];
   logic [PTR_W-1:0] ptr;
   ar_payload_t      ar_q;

   logic [N_CH-1:0]  eligible;
   logic             grant_any;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] next_ptr;
   logic             slot_open;
   ar_payload_t      ar_sel;

   logic [N_CH-1:0]  rid_hit;
   logic             route_hit;
   logic             beat_fire;
   logic             len_err;

   // Round-robin scan: first eligible index at or above ptr, else lowest eligible.
   always_comb begin
      eligible  = req_valid & ~busy;
      grant_any = 1'b0;
      winner    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!grant_any && eligible[i] && (PTR_W'(i) >= ptr)) begin
            grant_any = 1'b1;
            winner    = PTR_W'(i);
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (!grant_any && eligible[i]) begin
            grant_any = 1'b1;
            winner    = PTR_W'(i);
         end
      end
   end

   always_comb begin
      slot_open = ~arvalid | arready;
      next_ptr  = (winner == PTR_W'(N_CH - 1)) ? '0 : winner + PTR_W'(1);
      ar_sel    = '0;
      req_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (winner == PTR_W'(i)) begin
            ar_sel.id   = ID_W'(i);
            ar_sel.addr = req_addr[i*ADDR_W +: ADDR_W];
            ar_sel.len  = req_len[i*LEN_W +: LEN_W];
            ar_sel.size = req_size[i*SIZE_W +: SIZE_W];
            req_ready[i] = slot_open & grant_any;
         end
      end
   end

   // R routing by RID; beats for unknown or idle channels are drained.
   always_comb begin
      rid_hit = '0;
      len_err = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         rid_hit[i] = (rid == ID_W'(i)) & busy[i];
         if (rid_hit[i] && (rlast != (cnt[i] == exp_len[i]))) begin
            len_err = 1'b1;
         end
      end
      route_hit  = |rid_hit;
      resp_valid = rid_hit & {N_CH{rvalid}};
      rready     = route_hit ? |(rid_hit & resp_ready) : 1'b1;
      beat_fire  = rvalid & rready;
   end

   assign resp_data = rdata;
   assign resp_last = rlast;
   assign resp_err  = rresp[1];

   assign arid    = ar_q.id;
   assign araddr  = ar_q.addr;
   assign arlen   = ar_q.len;
   assign arsize  = ar_q.size;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   // AR channel register and round-robin pointer.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         arvalid <= 1'b0;
         ar_q    <= '0;
         ptr     <= '0;
      end else if (slot_open) begin
         arvalid <= grant_any;
         if (grant_any) begin
            ar_q <= ar_sel;
            ptr  <= next_ptr;
         end
      end
   end

   // Per-channel outstanding-burst tracking.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         busy <= '0;
         for (int i = 0; i < N_CH; i++) begin
            cnt[i]     <= '0;
            exp_len[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (req_ready[i]) begin
               busy[i]    <= 1'b1;
               cnt[i]     <= '0;
               exp_len[i] <= ar_sel.len;
            end else if (rid_hit[i] && beat_fire) begin
               if (rlast) begin
                  busy[i] <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] + LEN_W'(1);
               end
            end
         end
      end
   end

   // Sticky error: stray beat, or rlast disagreeing with the beat count.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         proto_err <= 1'b0;
      end else if (beat_fire && (!route_hit || len_err)) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter with N_CH=3, 32-bit address/data.
`timescale 1ns/1ps

module tb_axi_rd_arbiter;

   localparam int unsigned N_CH   = 3;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 4;

   logic                   aclk;
   logic                   areset;
   logic [N_CH-1:0]        req_valid;
   logic [N_CH-1:0]        req_ready;
   logic [N_CH*ADDR_W-1:0] req_addr;
   logic [N_CH*8-1:0]      req_len;
   logic [N_CH*3-1:0]      req_size;
   logic [N_CH-1:0]        resp_valid;
   logic [N_CH-1:0]        resp_ready;
   logic [DATA_W-1:0]      resp_data;
   logic                   resp_last;
   logic                   resp_err;
   logic                   proto_err;
   logic [ID_W-1:0]        arid;
   logic [ADDR_W-1:0]      araddr;
   logic [7:0]             arlen;
   logic [2:0]             arsize;
   logic [1:0]             arburst;
   logic [1:0]             arlock;
   logic [3:0]             arcache;
   logic [2:0]             arprot;
   logic                   arvalid;
   logic                   arready;
   logic [ID_W-1:0]        rid;
   logic [DATA_W-1:0]      rdata;
   logic [1:0]             rresp;
   logic                   rlast;
   logic                   rvalid;
   logic                   rready;

   int n_checks = 0;
   int n_errors = 0;

   axi_rd_arbiter #(
      .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
   ) dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_len(req_len), .req_size(req_size),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_last(resp_last), .resp_err(resp_err), .proto_err(proto_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid  = '0;
      req_addr   = '0;
      req_len    = '0;
      req_size   = '0;
      resp_ready = '0;
      arready    = 1'b0;
      rid        = '0;
      rdata      = '0;
      rresp      = '0;
      rlast      = 1'b0;
      rvalid     = 1'b0;
   endtask

   task automatic pulse_reset();
      clear_inputs();
      areset = 1'b1;
      #1;
      areset = 1'b0;
      #1;
   endtask

   task automatic beat(input int ch, input logic last, input logic [DATA_W-1:0] data);
      rid    = ID_W'(ch);
      rlast  = last;
      rdata  = data;
      rvalid = 1'b1;
   endtask

   initial begin
      int prev;
      int want_ch;

      // Reset state
      clear_inputs();
      areset = 1'b1;
      #3;
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_arid", 64'(arid), 64'd0);
      check("rst_araddr", 64'(araddr), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_proto_err", 64'(proto_err), 64'd0);
      check("rst_rready", 64'(rready), 64'd1);
      tick();
      areset = 1'b0;

      // Single request on channel 1
      req_valid = 3'b010;
      req_addr[1*ADDR_W +: ADDR_W] = 32'h1C00_0000;
      req_len[1*8 +: 8] = 8'd3;
      req_size[1*3 +: 3] = 3'd2;
      #1;
      check("single_req_ready", 64'(req_ready), 64'b010);
      check("single_no_early_arvalid", 64'(arvalid), 64'd0);
      tick();
      req_valid = '0;
      check("single_arvalid", 64'(arvalid), 64'd1);
      check("single_arid", 64'(arid), 64'd1);
      check("single_araddr", 64'(araddr), 64'h1C00_0000);
      check("single_arlen", 64'(arlen), 64'd3);
      check("single_arsize", 64'(arsize), 64'd2);
      check("single_arburst", 64'(arburst), 64'd1);
      check("single_const", 64'({arlock, arcache, arprot}), 64'd0);
      arready = 1'b1;
      tick();
      check("single_arvalid_drop", 64'(arvalid), 64'd0);
      arready = 1'b0;
      resp_ready = 3'b010;
      for (int b = 0; b < 4; b++) begin
         beat(1, (b == 3), 32'hA0 + 32'(b));
         #1;
         check("single_resp_valid", 64'(resp_valid), 64'b010);
         check("single_rready", 64'(rready), 64'd1);
         check("single_resp_data", 64'(resp_data), 64'hA0 + 64'(b));
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      check("single_proto_err", 64'(proto_err), 64'd0);
      req_valid = 3'b010;
      #1;
      check("single_busy_cleared", 64'(req_ready), 64'b010);
      req_valid = '0;

      // Round-robin with continuous requests and immediate single-beat returns
      pulse_reset();
      req_valid  = 3'b111;
      arready    = 1'b1;
      resp_ready = 3'b111;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         want_ch = k % 3;
         if (k > 0) beat(prev, 1'b1, 32'h0);
         #1;
         check("rr_grant", 64'(req_ready), 64'(1 << want_ch));
         if (k > 0) begin
            check("rr_arvalid", 64'(arvalid), 64'd1);
            check("rr_arid", 64'(arid), 64'(prev));
         end
         tick();
         prev = want_ch;
      end
      req_valid = '0;
      beat(prev, 1'b1, 32'h0);
      #1;
      check("rr_last_arid", 64'(arid), 64'(prev));
      tick();
      rvalid = 1'b0;
      check("rr_arvalid_idle", 64'(arvalid), 64'd0);
      check("rr_proto_err", 64'(proto_err), 64'd0);

      // AR backpressure and R backpressure
      pulse_reset();
      req_valid = 3'b001;
      req_addr[0 +: ADDR_W] = 32'h0000_1000;
      #1;
      check("bp_first_grant", 64'(req_ready), 64'b001);
      tick();
      req_valid = 3'b110;
      req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_2000;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_arvalid", 64'(arvalid), 64'd1);
         check("bp_araddr", 64'(araddr), 64'h1000);
         check("bp_arid", 64'(arid), 64'd0);
         tick();
      end
      req_valid = '0;
      beat(0, 1'b1, 32'h55);
      #1;
      check("bp_rready_low", 64'(rready), 64'd0);
      check("bp_resp_valid", 64'(resp_valid), 64'b001);
      tick();
      check("bp_rready_held", 64'(rready), 64'd0);
      resp_ready = 3'b001;
      #1;
      check("bp_rready_high", 64'(rready), 64'd1);
      tick();
      rvalid = 1'b0;
      check("bp_proto_err", 64'(proto_err), 64'd0);

      // Interleaved R beats for channels 0 (len 1) and 2 (len 2)
      pulse_reset();
      req_valid = 3'b101;
      req_len[0 +: 8] = 8'd1;
      req_len[2*8 +: 8] = 8'd2;
      arready = 1'b1;
      resp_ready = 3'b101;
      #1;
      check("il_grant0", 64'(req_ready), 64'b001);
      tick();
      check("il_grant2", 64'(req_ready), 64'b100);
      tick();
      req_valid = '0;
      beat(2, 1'b0, 32'h20); #1; check("il_b0", 64'(resp_valid), 64'b100); tick();
      beat(0, 1'b0, 32'h00); #1; check("il_b1", 64'(resp_valid), 64'b001); tick();
      beat(2, 1'b0, 32'h21); #1; check("il_b2", 64'(resp_valid), 64'b100); tick();
      beat(0, 1'b1, 32'h01); #1; check("il_b3", 64'(resp_valid), 64'b001); tick();
      beat(2, 1'b1, 32'h22); #1; check("il_b4", 64'(resp_valid), 64'b100); tick();
      rvalid = 1'b0;
      check("il_proto_err", 64'(proto_err), 64'd0);
      req_valid = 3'b100;
      #1;
      check("il_busy2_clear", 64'(req_ready), 64'b100);
      req_valid = 3'b001;
      #1;
      check("il_busy0_clear", 64'(req_ready), 64'b001);
      req_valid = '0;

      // Early rlast: channel 0 len 3, rlast on the third beat
      pulse_reset();
      req_valid = 3'b001;
      req_len[0 +: 8] = 8'd3;
      arready = 1'b1;
      resp_ready = 3'b001;
      tick();
      req_valid = '0;
      beat(0, 1'b0, 32'h0); tick();
      beat(0, 1'b0, 32'h1); tick();
      check("mm_no_err_yet", 64'(proto_err), 64'd0);
      beat(0, 1'b1, 32'h2); tick();
      rvalid = 1'b0;
      check("mm_proto_err", 64'(proto_err), 64'd1);
      req_valid = 3'b001;
      #1;
      check("mm_busy_clear", 64'(req_ready), 64'b001);
      req_valid = '0;
      beat(7, 1'b1, 32'h0);
      #1;
      check("mm_stray_rready", 64'(rready), 64'd1);
      check("mm_stray_resp_valid", 64'(resp_valid), 64'd0);
      tick();
      rvalid = 1'b0;
      tick();
      check("mm_sticky", 64'(proto_err), 64'd1);

      // Missing rlast: channel 0 len 0, first beat without rlast
      pulse_reset();
      req_valid = 3'b001;
      arready = 1'b1;
      resp_ready = 3'b001;
      tick();
      req_valid = '0;
      beat(0, 1'b0, 32'h0);
      tick();
      rvalid = 1'b0;
      check("ml_proto_err", 64'(proto_err), 64'd1);
      req_valid = 3'b001;
      #1;
      check("ml_still_busy", 64'(req_ready), 64'd0);
      beat(0, 1'b1, 32'h1);
      #1;
      check("ml_late_last_routed", 64'(resp_valid), 64'b001);
      tick();
      rvalid = 1'b0;
      #1;
      check("ml_busy_clear", 64'(req_ready), 64'b001);
      req_valid = '0;

      // Asynchronous reset mid-burst, then a stray beat
      pulse_reset();
      req_valid = 3'b001;
      req_addr[0 +: ADDR_W] = 32'h0000_4000;
      req_len[0 +: 8] = 8'd3;
      resp_ready = 3'b001;
      tick();
      req_valid = '0;
      beat(0, 1'b0, 32'h0);
      tick();
      rvalid = 1'b0;
      check("ar_pre_arvalid", 64'(arvalid), 64'd1);
      #2;
      areset = 1'b1;
      #1;
      check("ar_arvalid", 64'(arvalid), 64'd0);
      check("ar_araddr", 64'(araddr), 64'd0);
      check("ar_arlen", 64'(arlen), 64'd0);
      check("ar_proto_err", 64'(proto_err), 64'd0);
      areset = 1'b0;
      beat(0, 1'b1, 32'h9);
      #1;
      check("ar_stray_rready", 64'(rready), 64'd1);
      check("ar_stray_resp_valid", 64'(resp_valid), 64'd0);
      tick();
      rvalid = 1'b0;
      check("ar_stray_proto_err", 64'(proto_err), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
